// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit order,
// the blank pattern and the active-low hex glyphs used by the encoder.
package seven_segment_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_0 = 7'b1000000;
    localparam logic [6:0] HEX_1 = 7'b1111001;
    localparam logic [6:0] HEX_2 = 7'b0100100;
    localparam logic [6:0] HEX_3 = 7'b0110000;
    localparam logic [6:0] HEX_4 = 7'b0011001;
    localparam logic [6:0] HEX_5 = 7'b0010010;
    localparam logic [6:0] HEX_6 = 7'b0000010;
    localparam logic [6:0] HEX_7 = 7'b1111000;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0010000;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b0000011;
    localparam logic [6:0] HEX_C = 7'b1000110;
    localparam logic [6:0] HEX_D = 7'b0100001;
    localparam logic [6:0] HEX_E = 7'b0000110;
    localparam logic [6:0] HEX_F = 7'b0001110;

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Application-side and pin-side signals of the scan controller.
interface seven_segment_scan_controller_if #(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned BRIGHTNESS_BITS = 4
) ();
    logic [NUM_DIGITS*4-1:0]    data;
    logic [NUM_DIGITS-1:0]      pointEnable;
    logic [NUM_DIGITS-1:0]      blankMask;
    logic                       load;
    logic                       suppressZeros;
    logic [BRIGHTNESS_BITS-1:0] brightness;
    logic [7:0]                 segmentEnableN;
    logic [NUM_DIGITS-1:0]      digitEnableN;
    logic                       frameStart;
    logic                       loadPending;

    modport master (
        output data, pointEnable, blankMask, load, suppressZeros, brightness,
        input  segmentEnableN, digitEnableN, frameStart, loadPending
    );

    modport slave (
        input  data, pointEnable, blankMask, load, suppressZeros, brightness,
        output segmentEnableN, digitEnableN, frameStart, loadPending
    );
endinterface

// File: rtl/SevenSegmentEncoder.sv
// Nibble to active-low {g,f,e,d,c,b,a} glyph conversion.
module SevenSegmentEncoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);
    always_comb begin
        segments = SEG_BLANK[6:0];
        unique case (nibble)
            4'h0: segments = HEX_0;
            4'h1: segments = HEX_1;
            4'h2: segments = HEX_2;
            4'h3: segments = HEX_3;
            4'h4: segments = HEX_4;
            4'h5: segments = HEX_5;
            4'h6: segments = HEX_6;
            4'h7: segments = HEX_7;
            4'h8: segments = HEX_8;
            4'h9: segments = HEX_9;
            4'hA: segments = HEX_A;
            4'hB: segments = HEX_B;
            4'hC: segments = HEX_C;
            4'hD: segments = HEX_D;
            4'hE: segments = HEX_E;
            4'hF: segments = HEX_F;
        endcase
    end
endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scanner with double-buffered display data,
// per-digit PWM brightness, blanking and leading-zero suppression.
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned TICK_BITS       = 17,
    parameter int unsigned BRIGHTNESS_BITS = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    seven_segment_scan_controller_if.slave bus
);
    localparam int unsigned IDX_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS*4-1:0] data;
        logic [NUM_DIGITS-1:0]   point;
        logic [NUM_DIGITS-1:0]   blank;
    } frame_t;

    logic [TICK_BITS-1:0]       tick_q;
    logic [IDX_BITS-1:0]        idx_q;
    frame_t                     active_q, pending_q, live;
    logic [BRIGHTNESS_BITS-1:0] bright_q;
    logic                       load_pending_q, frame_start_q;
    logic [7:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      dig_q, dig_d;

    logic                       tick_done, boundary, lit, suppressed, dark;
    logic [BRIGHTNESS_BITS-1:0] phase;
    logic [NUM_DIGITS-1:0]      zero_from;
    logic [3:0]                 sel_nibble;
    logic [6:0]                 pattern;

    assign live      = {bus.data, bus.pointEnable, bus.blankMask};
    assign tick_done = &tick_q;
    assign boundary  = tick_done && (idx_q == LAST_IDX);
    assign phase     = tick_q[TICK_BITS-1 -: BRIGHTNESS_BITS];
    assign lit       = (phase <= bright_q);

    // zero_from[i]: digit i and everything more significant is a bare zero
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run          = run && (active_q.data[i*4 +: 4] == 4'h0) && !active_q.point[i];
            zero_from[i] = run;
        end
    end

    assign sel_nibble = active_q.data[{idx_q, 2'b00} +: 4];
    assign suppressed = bus.suppressZeros && (idx_q != '0) && zero_from[idx_q];
    assign dark       = active_q.blank[idx_q] || suppressed || !lit;

    SevenSegmentEncoder u_encoder (
        .nibble   (sel_nibble),
        .segments (pattern)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        dig_d = '1;
        if (!dark) begin
            seg_d         = {1'b1, pattern};
            seg_d[SEG_DP] = ~active_q.point[idx_q];
            dig_d         = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q         <= '0;
            idx_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            bright_q       <= '0;
            load_pending_q <= 1'b0;
            frame_start_q  <= 1'b0;
            seg_q          <= SEG_BLANK;
            dig_q          <= '1;
        end else begin
            tick_q        <= tick_q + 1'b1;
            frame_start_q <= boundary;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            if (tick_done) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
            if (bus.load) begin
                pending_q <= live;
            end
            // A load landing on the boundary bypasses pending entirely
            if (boundary) begin
                active_q       <= bus.load ? live : pending_q;
                bright_q       <= bus.brightness;
                load_pending_q <= 1'b0;
            end else if (bus.load) begin
                load_pending_q <= 1'b1;
            end
        end
    end

    assign bus.segmentEnableN = seg_q;
    assign bus.digitEnableN   = dig_q;
    assign bus.frameStart     = frame_start_q;
    assign bus.loadPending    = load_pending_q;
endmodule

// File: doc/seven_segment_scan_controller.md
# seven_segment_scan_controller

Next-generation multiplexed seven-segment driver for boards such as the Nexys A7: all digits share one segment bus, and each digit has its own enable. It scans a configurable number of digits and adds per-digit PWM brightness, per-digit blanking and leading-zero suppression. Display data is double-buffered, so a new value is applied only at a frame boundary and never tears. It sits between application logic, which supplies hex nibbles, and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- TICK_BITS, 17, each digit slot lasts 2^TICK_BITS clocks (≈763 Hz slot rate at 100 MHz); must be ≥ BRIGHTNESS_BITS
- BRIGHTNESS_BITS, 4, width of the brightness control
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data  input  NUM_DIGITS*4  nibble i drives digit i; digit NUM_DIGITS-1 is most significant
- pointEnable  input  NUM_DIGITS  active-high decimal point per digit
- blankMask  input  NUM_DIGITS  active-high forced blank per digit
- load  input  1  one-cycle strobe; captures data/pointEnable/blankMask into the pending buffer
- suppressZeros  input  1  enables leading-zero suppression
- brightness  input  BRIGHTNESS_BITS  duty level; sampled at frame start
- segmentEnableN  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered
- digitEnableN  output  NUM_DIGITS  active-low digit enables, registered, at most one low
- frameStart  output  1  one-cycle pulse when the scan returns to digit 0
- loadPending  output  1  high while the pending buffer has not yet been applied

## Operation
- **Counters.** tickCount (TICK_BITS) increments every clock. On its terminal count the digit index advances. The index wraps from NUM_DIGITS-1 to 0.
- **Frame boundary.** This is the cycle in which the index wraps to 0. In that cycle:
  - the active buffer takes the pending buffer;
  - brightnessActive takes brightness;
  - frameStart pulses;
  - loadPending clears.
- **load.** load captures the inputs into pending and sets loadPending.
  - If load coincides with a frame boundary, the active buffer takes the live inputs directly and loadPending stays 0.
  - Repeated loads before a boundary overwrite pending; the last one wins.
- **PWM.** phase = tickCount[TICK_BITS-1 -: BRIGHTNESS_BITS]. The digit is lit while phase ≤ brightnessActive.
  - brightness 0 gives a duty of 1/2^BRIGHTNESS_BITS.
  - The all-ones value gives 100% duty.
- **Leading-zero suppression.** Digit i (i>0) is suppressed when suppressZeros=1 and, for every j from i to NUM_DIGITS-1, nibble j = 0 and pointEnable j = 0. Digit 0 is never suppressed. suppressZeros is applied live, not buffered.
- **Dark digit.** A digit is dark when it is blanked, suppressed, or in the PWM off phase. A dark digit drives digitEnableN all ones and segmentEnableN all ones.
- **Segments.** Hex patterns 0–F come from the existing encoder. The dp bit follows pointEnable.

## Timing
- **Reset** (synchronous, any cycle, including mid-frame or with loadPending set):
  - tickCount, digit index, active buffer, pending buffer, brightnessActive and loadPending all go to 0;
  - segmentEnableN = 8'hFF, digitEnableN = all ones, frameStart = 0.
- **Output latency.** Outputs are registered, one clock after the counter state that selects them.
  - The first lit output appears the second cycle after reset deasserts.
  - At that point it shows digit 0 with active data 0, i.e. "0".
- **Frame length.** Exactly NUM_DIGITS·2^TICK_BITS clocks. frameStart recurs with that period and is high for one cycle.
- **Load-to-display latency.** Data becomes visible in the first cycle of the next frame, plus the one-cycle output register.
- **brightness changes.** A mid-frame change has no effect until the next frame boundary.

## Structure
- **Shared package `seven_segment_pkg`:**
  - SEG_BLANK = 8'hFF;
  - segment bit-order localparams;
  - hex pattern constants used by the encoder.
- **Sub-module:** reuse SevenSegmentEncoder for nibble→segment conversion, one instance on the selected digit.
- **Top level:** counters, buffers, suppression logic and output registers are implemented in this module.

## Test plan
All scenarios run with NUM_DIGITS=4, TICK_BITS=4, BRIGHTNESS_BITS=2.
- **Reset and first frame.** reset, then load data=16'h12AF with brightness=3 at the first boundary → frame 2 shows digit0=F, digit1=A, digit2=2, digit3=1. digitEnableN cycles 1110, 1101, 1011, 0111, 16 clocks each. frameStart period is 64.
- **PWM.** brightness=1 → within each 16-clock slot the digit is low for 8 clocks, then all ones for 8 clocks.
- **Tear-free load.** load 16'h1111 mid-frame → the current frame still shows the old value and loadPending=1. The new value appears at the next frameStart+1 and loadPending drops. A load coinciding with a frame boundary applies immediately with loadPending=0.
- **Zero suppression.** suppressZeros=1, data=16'h0040 → digits 3 and 2 are dark, digit1=4, digit0=0. Same data with pointEnable=4'b1000 → all digits lit.
- **Blanking.** blankMask=4'b0101 → digits 0 and 2 drive all ones on both buses for their whole slot.
- **Mid-frame reset.** Assert reset during digit 2 with loadPending=1 → next cycle segmentEnableN=8'hFF and digitEnableN=4'hF. The scan restarts at digit 0, displaying 0.
